// File: rtl/sgd_pkg.sv
// Shared types and fixed-point helpers for the SGD linear-regression trainer.
package sgd_pkg;

   localparam int LR_W     = 4;
   localparam int EPOCH_W  = 8;
   localparam int MAX_WORD = 1024;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LREQ,
      S_LWAIT,
      S_FETCH,
      S_WAIT,
      S_MUL,
      S_ERR,
      S_UPD,
      S_DONE
   } state_t;

   // Clamp a sign-extended value to the signed range of a w-bit word.
   function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Slot j of a RAM word; slot 0 occupies the most significant field.
   function automatic logic [63:0] slot(input logic [MAX_WORD-1:0] word, input int unsigned j,
                                        input int unsigned n_feat, input int unsigned w);
      return 64'(word >> ((n_feat - j) * w)) & ((64'd1 << w) - 64'd1);
   endfunction

endpackage

// File: rtl/sgd_lane.sv
// One feature lane: holds W_j and x_j, and shares a single multiply/shift/saturate
// path between the prediction product (W_j*x_j) and the gradient product (err*x_j).
module sgd_lane
   import sgd_pkg::*;
#(
   parameter int W_DATA = 16,
   parameter int FRAC   = 8
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     w_load,
   input  logic signed [W_DATA-1:0] w_init,
   input  logic                     x_load,
   input  logic signed [W_DATA-1:0] x_in,
   input  logic                     mul_en,
   input  logic                     upd_en,
   input  logic signed [W_DATA-1:0] err,
   input  logic        [LR_W-1:0]   learn_rate,
   output logic signed [W_DATA-1:0] w,
   output logic signed [W_DATA-1:0] p,
   output logic                     sat_hit
);

   logic signed [W_DATA-1:0]   x;
   logic signed [W_DATA-1:0]   opa;
   logic signed [2*W_DATA-1:0] prod;
   logic signed [63:0]         shf;
   logic signed [63:0]         sum;
   logic signed [W_DATA-1:0]   s;
   logic signed [W_DATA-1:0]   wn;
   logic                       s_sat;
   logic                       u_sat;

   always_comb begin
      opa     = upd_en ? err : w;
      prod    = opa * x;
      shf     = 64'(prod);
      shf     = shf >>> FRAC;
      s       = W_DATA'(sat(shf, W_DATA));
      s_sat   = (64'(s) != shf);
      sum     = 64'(w) + (64'(s) >>> learn_rate);
      wn      = W_DATA'(sat(sum, W_DATA));
      u_sat   = (64'(wn) != sum);
      sat_hit = (mul_en & s_sat) | (upd_en & (s_sat | u_sat));
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         w <= '0;
         x <= '0;
         p <= '0;
      end else begin
         if (w_load)      w <= w_init;
         else if (upd_en) w <= wn;
         if (x_load)      x <= x_in;
         if (mul_en)      p <= s;
      end
   end

endmodule

// File: rtl/sgd_trainer.sv
// SGD linear-regression trainer: streams points from a fixed-latency RAM and
// trains bias plus N_FEAT saturating fixed-point weights over several epochs.
module sgd_trainer
   import sgd_pkg::*;
#(
   parameter int N_FEAT     = 4,
   parameter int W_DATA     = 16,
   parameter int FRAC       = 8,
   parameter int ADDR_WIDTH = 12,
   parameter int RD_LAT     = 1
) (
   input  logic                           CLK,
   input  logic                           RST_N,
   input  logic                           start,
   input  logic [ADDR_WIDTH-1:0]          n_points,
   input  logic [EPOCH_W-1:0]             epochs,
   input  logic [LR_W-1:0]                learn_rate,
   input  logic                           hold,
   output logic                           mem_req,
   output logic [ADDR_WIDTH-1:0]          mem_addr,
   input  logic [(N_FEAT+1)*W_DATA-1:0]   mem_rdata,
   input  logic [3:0]                     w_sel,
   output logic [W_DATA-1:0]              w_out,
   output logic                           busy,
   output logic                           done,
   output logic [EPOCH_W-1:0]             epoch_cnt,
   output logic                           sat_flag
);

   localparam int AW = W_DATA + 4;

   state_t                   state, state_nx;
   logic [ADDR_WIDTH-1:0]    n_r, dp;
   logic [EPOCH_W-1:0]       ep_r, ep_inc;
   logic [LR_W-1:0]          lr_r;
   logic [7:0]               wcnt;
   logic                     wlast;
   logic signed [W_DATA-1:0] w0, y_r, err_r;
   logic signed [W_DATA-1:0] lw [N_FEAT];
   logic signed [W_DATA-1:0] lp [N_FEAT];
   logic [N_FEAT-1:0]        lane_sat;
   logic [MAX_WORD-1:0]      word;
   logic                     ld_w, ld_x;
   logic signed [AW-1:0]     acc;
   logic signed [W_DATA-1:0] yhat, err_nx, w0_nx;
   logic signed [63:0]       dif, w0s;
   logic                     yh_sat, e_sat, w0_sat, any_sat;

   assign word   = MAX_WORD'(mem_rdata);
   assign wlast  = (wcnt == 8'(RD_LAT - 1));
   assign ep_inc = epoch_cnt + 8'd1;
   assign ld_w   = (state == S_LWAIT) && wlast;
   assign ld_x   = (state == S_WAIT) && wlast;

   for (genvar g = 0; g < N_FEAT; g++) begin : g_lane
      localparam int unsigned J = g + 1;
      sgd_lane #(.W_DATA(W_DATA), .FRAC(FRAC)) u_lane (
         .CLK        (CLK),
         .RST_N      (RST_N),
         .w_load     (ld_w),
         .w_init     (W_DATA'(slot(word, J, N_FEAT, W_DATA))),
         .x_load     (ld_x),
         .x_in       (W_DATA'(slot(word, J, N_FEAT, W_DATA))),
         .mul_en     (state == S_MUL),
         .upd_en     (state == S_UPD),
         .err        (err_r),
         .learn_rate (lr_r),
         .w          (lw[g]),
         .p          (lp[g]),
         .sat_hit    (lane_sat[g])
      );
   end

   always_comb begin
      state_nx = state;
      mem_req  = 1'b0;
      mem_addr = '0;
      busy     = (state != S_IDLE) && (state != S_DONE);
      done     = (state == S_DONE);
      case (state)
         S_IDLE:  if (start) state_nx = S_LREQ;
         S_LREQ: begin
            mem_req  = 1'b1;
            state_nx = S_LWAIT;
         end
         S_LWAIT: if (wlast) state_nx = (ep_r == '0 || n_r == '0) ? S_DONE : S_FETCH;
         S_FETCH: if (!hold) begin
            mem_req  = 1'b1;
            mem_addr = dp;
            state_nx = S_WAIT;
         end
         S_WAIT:  if (wlast) state_nx = S_MUL;
         S_MUL:   state_nx = S_ERR;
         S_ERR:   state_nx = S_UPD;
         S_UPD:   state_nx = (dp == n_r && ep_inc == ep_r) ? S_DONE : S_FETCH;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Prediction, error and bias update; the wide accumulator keeps the sum exact before clamping.
   always_comb begin
      acc = AW'(w0);
      for (int unsigned k = 0; k < N_FEAT; k++) acc = acc + AW'(lp[k]);
      yhat    = W_DATA'(sat(64'(acc), W_DATA));
      yh_sat  = (AW'(yhat) != acc);
      dif     = 64'(y_r) - 64'(yhat);
      err_nx  = W_DATA'(sat(dif, W_DATA));
      e_sat   = (64'(err_nx) != dif);
      w0s     = 64'(w0) + (64'(err_r) >>> lr_r);
      w0_nx   = W_DATA'(sat(w0s, W_DATA));
      w0_sat  = (64'(w0_nx) != w0s);
      any_sat = (|lane_sat) | ((state == S_ERR) & (yh_sat | e_sat)) | ((state == S_UPD) & w0_sat);
   end

   always_comb begin
      w_out = '0;
      if (w_sel == 4'd0) w_out = w0;
      for (int unsigned k = 1; k <= N_FEAT; k++)
         if (w_sel == 4'(k)) w_out = lw[k-1];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         n_r       <= '0;
         ep_r      <= '0;
         lr_r      <= '0;
         dp        <= '0;
         wcnt      <= '0;
         w0        <= '0;
         y_r       <= '0;
         err_r     <= '0;
         epoch_cnt <= '0;
         sat_flag  <= 1'b0;
      end else begin
         if (state == S_LWAIT || state == S_WAIT) wcnt <= wlast ? 8'd0 : wcnt + 8'd1;
         else                                     wcnt <= '0;
         if (state == S_IDLE && start) begin
            n_r       <= n_points;
            ep_r      <= epochs;
            lr_r      <= learn_rate;
            epoch_cnt <= '0;
            sat_flag  <= 1'b0;
         end else if (any_sat) begin
            sat_flag <= 1'b1;
         end
         if (ld_w) begin
            w0 <= W_DATA'(slot(word, 0, N_FEAT, W_DATA));
            dp <= ADDR_WIDTH'(1);
         end
         if (ld_x) y_r <= W_DATA'(slot(word, 0, N_FEAT, W_DATA));
         if (state == S_ERR) err_r <= err_nx;
         if (state == S_UPD) begin
            w0 <= w0_nx;
            if (dp == n_r) begin
               dp        <= ADDR_WIDTH'(1);
               epoch_cnt <= ep_inc;
            end else begin
               dp <= dp + ADDR_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sgd_trainer.sv
// Scoreboard bench for sgd_trainer: each launched job queues its expected result,
// and a monitor checks counters, flags and weights whenever done pulses.
module tb_sgd_trainer;

   localparam int N_FEAT = 2;
   localparam int W_DATA = 16;
   localparam int AWID   = 12;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        start;
   logic [11:0] n_points;
   logic [7:0]  epochs;
   logic [3:0]  learn_rate;
   logic        hold;
   logic        mem_req;
   logic [11:0] mem_addr;
   logic [47:0] mem_rdata;
   logic [3:0]  w_sel;
   logic [15:0] w_out;
   logic        busy, done, sat_flag;
   logic [7:0]  epoch_cnt;

   logic [47:0] ram [4096];

   int unsigned cyc = 0;
   int unsigned req_total = 0;
   int unsigned hreq_total = 0;
   int tests = 0;
   int fails = 0;

   typedef struct {
      int unsigned lat;
      logic [15:0] w0, w1, w2;
      int          tol;
      logic        sat;
      logic [7:0]  ep;
      int unsigned nreq;
      int unsigned t0, rbase, hbase;
   } exp_t;

   exp_t q[$];

   sgd_trainer #(.N_FEAT(N_FEAT), .W_DATA(W_DATA), .FRAC(8), .ADDR_WIDTH(AWID), .RD_LAT(1)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .n_points(n_points), .epochs(epochs),
      .learn_rate(learn_rate), .hold(hold), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .w_sel(w_sel), .w_out(w_out), .busy(busy), .done(done),
      .epoch_cnt(epoch_cnt), .sat_flag(sat_flag)
   );

   always #10 CLK = ~CLK;

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (mem_req) begin
         mem_rdata <= ram[mem_addr];
         req_total <= req_total + 1;
         if (hold) hreq_total <= hreq_total + 1;
      end
   end

   task automatic chk(input string nm, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, req, req);
      end
   endtask

   task automatic chk_tol(input string nm, input int act, input int req, input int tol);
      tests++;
      if (act > req + tol || act < req - tol) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, req, tol);
      end
   endtask

   function automatic exp_t mk(input int unsigned lat, input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input int tol, input logic s,
                               input logic [7:0] ep, input int unsigned nreq);
      exp_t e;
      e.lat = lat; e.w0 = w0; e.w1 = w1; e.w2 = w2; e.tol = tol;
      e.sat = s; e.ep = ep; e.nreq = nreq; e.t0 = 0; e.rbase = 0; e.hbase = 0;
      return e;
   endfunction

   // Monitor: owns w_sel and consumes one expectation per done pulse.
   initial begin
      exp_t e;
      w_sel = 4'd0;
      forever begin
         @(negedge CLK);
         if (done === 1'b1) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending job", cyc);
            end else begin
               e = q.pop_front();
               chk("done_cycle", int'(cyc - e.t0), int'(e.lat));
               chk("busy_at_done", int'(busy), 0);
               chk("mem_req_count", int'(req_total - e.rbase), int'(e.nreq));
               chk("req_during_hold", int'(hreq_total - e.hbase), 0);
               chk("epoch_cnt", int'(epoch_cnt), int'(e.ep));
               chk("sat_flag", int'(sat_flag), int'(e.sat));
               w_sel = 4'd0;  #1 chk_tol("w0", int'($signed(w_out)), int'($signed(e.w0)), e.tol);
               w_sel = 4'd1;  #1 chk_tol("w1", int'($signed(w_out)), int'($signed(e.w1)), e.tol);
               w_sel = 4'd2;  #1 chk("w2", int'(w_out), int'(e.w2));
               w_sel = 4'd3;  #1 chk("w_sel_3_zero", int'(w_out), 0);
               w_sel = 4'd15; #1 chk("w_sel_15_zero", int'(w_out), 0);
               w_sel = 4'd0;
            end
         end
      end
   end

   task automatic launch(input logic [11:0] n, input logic [7:0] ep, input logic [3:0] lr,
                         input bit push, input exp_t e);
      @(negedge CLK);
      n_points = n; epochs = ep; learn_rate = lr; start = 1'b1;
      e.t0 = cyc; e.rbase = req_total; e.hbase = hreq_total;
      if (push) q.push_back(e);
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic wait_jobs();
      int k = 0;
      while (q.size() != 0 && k < 3000) begin
         @(negedge CLK);
         k++;
      end
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL job_timeout: got %0d pending jobs after %0d cycles, expected 0", q.size(), k);
         q.delete();
      end
   endtask

   task automatic ram_test1();
      ram[0] = {16'h0000, 16'h0000, 16'h0000};
      ram[1] = {16'h0100, 16'h0100, 16'h0000};
   endtask

   task automatic ram_test3();
      ram[0] = {16'h8000, 16'h0000, 16'h0000};
      ram[1] = {16'h7FFF, 16'h0000, 16'h0000};
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected bench to complete");
      $fatal(1);
   end

   initial begin
      RST_N = 1'b0; start = 1'b0; n_points = '0; epochs = '0; learn_rate = '0; hold = 1'b0;
      for (int i = 0; i < 8; i++) ram[i] = '0;
      repeat (3) @(negedge CLK);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_mem_req", int'(mem_req), 0);
      chk("rst_epoch_cnt", int'(epoch_cnt), 0);
      chk("rst_sat_flag", int'(sat_flag), 0);
      chk("rst_w_out", int'(w_out), 0);
      RST_N = 1'b1;
      @(negedge CLK);

      // Single update
      ram_test1();
      launch(12'd1, 8'd1, 4'd1, 1'b1, mk(8, 16'h0080, 16'h0080, 16'h0000, 0, 1'b0, 8'd1, 2));
      wait_jobs();

      // Convergence on y = 2*x1 + 1
      ram[0] = {16'h0000, 16'h0000, 16'h0000};
      ram[1] = {16'h0100, 16'h0000, 16'h0000};
      ram[2] = {16'h0200, 16'h0080, 16'h0000};
      ram[3] = {16'h0300, 16'h0100, 16'h0000};
      ram[4] = {16'h0400, 16'h0180, 16'h0000};
      launch(12'd4, 8'd50, 4'd3, 1'b1, mk(1003, 16'h0100, 16'h0200, 16'h0000, 8, 1'b0, 8'd50, 201));
      wait_jobs();

      // Saturation of err
      ram_test3();
      launch(12'd1, 8'd1, 4'd0, 1'b1, mk(8, 16'hFFFF, 16'h0000, 16'h0000, 0, 1'b1, 8'd1, 2));
      wait_jobs();

      // Hold for 10 cycles in FETCH; sat_flag from the previous job must be cleared
      ram_test1();
      launch(12'd1, 8'd1, 4'd1, 1'b1, mk(18, 16'h0080, 16'h0080, 16'h0000, 0, 1'b0, 8'd1, 2));
      @(negedge CLK);
      hold = 1'b1;
      repeat (11) @(negedge CLK);
      hold = 1'b0;
      wait_jobs();

      // Zero counts: epochs == 0, then n_points == 0
      ram[0] = {16'h0123, 16'hFF00, 16'h0040};
      launch(12'd2, 8'd0, 4'd1, 1'b1, mk(3, 16'h0123, 16'hFF00, 16'h0040, 0, 1'b0, 8'd0, 1));
      wait_jobs();
      launch(12'd0, 8'd3, 4'd1, 1'b1, mk(3, 16'h0123, 16'hFF00, 16'h0040, 0, 1'b0, 8'd0, 1));
      wait_jobs();

      // Start while busy is ignored
      ram_test1();
      launch(12'd1, 8'd1, 4'd1, 1'b1, mk(8, 16'h0080, 16'h0080, 16'h0000, 0, 1'b0, 8'd1, 2));
      repeat (3) @(negedge CLK);
      epochs = 8'd7; n_points = 12'd3; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      wait_jobs();

      // Reset during ERR of the second epoch of a saturating run
      ram_test3();
      launch(12'd1, 8'd2, 4'd0, 1'b0, mk(0, 16'h0, 16'h0, 16'h0, 0, 1'b0, 8'd0, 0));
      repeat (10) @(negedge CLK);
      chk("pre_rst_busy", int'(busy), 1);
      chk("pre_rst_epoch_cnt", int'(epoch_cnt), 1);
      chk("pre_rst_sat_flag", int'(sat_flag), 1);
      chk("pre_rst_w0", int'(w_out), 16'hFFFF);
      RST_N = 1'b0;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_mem_req", int'(mem_req), 0);
      chk("midrst_epoch_cnt", int'(epoch_cnt), 0);
      chk("midrst_sat_flag", int'(sat_flag), 0);
      chk("midrst_w0", int'(w_out), 0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      ram_test1();
      launch(12'd1, 8'd1, 4'd1, 1'b1, mk(8, 16'h0080, 16'h0080, 16'h0000, 0, 1'b0, 8'd1, 2));
      wait_jobs();

      repeat (3) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sgd_trainer.md
# sgd_trainer

Parametrised stochastic-gradient-descent linear-regression trainer. It is the next-generation replacement for the fixed 15-feature, 16-bit trainer. It streams data points from an external synchronous RAM with a fixed read latency, and trains bias plus N_FEAT weights in signed fixed point with saturation. It runs for a programmable number of epochs, then exposes the weights through a read port. It sits between the dataset RAM and the host control/readout logic.

## Interface
- N_FEAT, 4: feature count (1..15).
- W_DATA, 16: signed width of every feature, target and weight.
- FRAC, 8: fractional bits (Q(W_DATA-FRAC).FRAC).
- ADDR_WIDTH, 12: RAM address width.
- RD_LAT, 1: RAM read latency in cycles (≥1).
- CLK  in  1  clock; single clock domain.
- RST_N  in  1  reset; asynchronous assert, active-low.
- start  in  1  one-cycle start pulse; accepted only in IDLE.
- n_points  in  ADDR_WIDTH  data point count; latched at start.
- epochs  in  8  epoch count; latched at start.
- learn_rate  in  4  right-shift learning rate; latched at start.
- hold  in  1  pause request.
- mem_req  out  1  RAM read strobe.
- mem_addr  out  ADDR_WIDTH  RAM read address.
- mem_rdata  in  (N_FEAT+1)*W_DATA  RAM word. Slot j (0..N_FEAT) is at bits [(N_FEAT+1-j)*W_DATA-1 -: W_DATA]. Slot 0 holds y (or W0 at address 0).
- w_sel  in  4  weight index for readout.
- w_out  out  W_DATA  W[w_sel], combinational; 0 if w_sel > N_FEAT.
- busy  out  1  high from the cycle after start until DONE.
- done  out  1  one-cycle completion pulse.
- epoch_cnt  out  8  completed epochs.
- sat_flag  out  1  sticky; set on any saturation, cleared at start.

## Operation
- **Data layout.** Address 0 holds the initial weights W0..WN. Addresses 1..n_points hold the data points.
- **States.** IDLE, LREQ, LWAIT, FETCH, WAIT, MUL, ERR, UPD, DONE.
- **IDLE.** On start: latch the inputs, clear epoch_cnt and sat_flag, go to LREQ.
- **LREQ.** Drive mem_req=1 and mem_addr=0, go to LWAIT.
- **LWAIT.** Stay RD_LAT cycles. On the last cycle, capture W from mem_rdata.
  - If epochs==0 or n_points==0, go to DONE.
  - Otherwise set dp=1 and go to FETCH.
- **FETCH.** If hold=1, stay and issue no request. Otherwise drive mem_req=1 and mem_addr=dp, go to WAIT.
- **WAIT.** Stay RD_LAT cycles. On the last cycle, register x[1..N] and y.
- **MUL.** Register p_j = sat((W_j*x_j) >>> FRAC).
- **ERR.**
  - Form yhat = sat(W0 + Σp_j), using a full-width accumulator of W_DATA+4 bits.
  - Register err = sat(y − yhat).
- **UPD.** Apply the update:
  - W_j ← sat(W_j + (sat((err*x_j) >>> FRAC) >>> learn_rate)).
  - W0 ← sat(W0 + (err >>> learn_rate)).
  - If dp==n_points: set dp=1 and increment epoch_cnt. If the new epoch_cnt equals epochs, go to DONE; otherwise go to FETCH.
  - If dp<n_points: increment dp and go to FETCH.
- **DONE.** done=1 and busy=0 for one cycle, then IDLE. Weights are held until the next start.
- **Arithmetic.**
  - Products are full 2*W_DATA signed.
  - >>> is arithmetic shift.
  - sat clamps to [−2^(W_DATA−1), 2^(W_DATA−1)−1] and sets sat_flag.
- **hold.** Honoured only in FETCH. A read in flight always completes.
- **start while busy.** Ignored.
- **Reset.** RST_N low at any time forces all of the following to 0, asynchronously: all state (to IDLE), W, counters, sat_flag, mem_req, done and busy.

## Timing
- start is sampled in cycle 0.
- LREQ is cycle 1. Weights are loaded at the end of cycle RD_LAT+1.
- Each point takes RD_LAT+4 cycles (FETCH, WAIT×RD_LAT, MUL, ERR, UPD), excluding hold stalls.
- done is asserted in cycle RD_LAT+2 + epochs·n_points·(RD_LAT+4).
- With epochs==0 or n_points==0, done is asserted in cycle RD_LAT+2.
- mem_req is a single-cycle pulse. mem_rdata is sampled exactly RD_LAT cycles after it.
- Weight registers change only at the end of UPD or LWAIT.

## Structure
- **Package sgd_pkg:**
  - state enum;
  - sat(value, width) function;
  - slot(word, j) extraction function;
  - LR_W=4 and EPOCH_W=8 constants.
- **Sub-module sgd_lane:** one per feature. It holds W_j and implements the multiply/shift/saturate path. It is reused for the MUL and UPD products through an operand mux.

## Test plan
Defaults for all tests: N_FEAT=2, FRAC=8, RD_LAT=1.
1. **Single update.** W=0, point x1=0x0100, x2=0, y=0x0100, lr=1, epochs=1, n_points=1 -> W0=0x0080, W1=0x0080, W2=0, done in cycle 8, sat_flag=0.
2. **Convergence.** Four points on y=2·x1+1, lr=3, epochs=50 -> W1 within ±0x0008 of 0x0200, W0 within ±0x0008 of 0x0100, epoch_cnt=50.
3. **Saturation.** W0=0x8000, x=0, y=0x7FFF, lr=0 -> err clamps to 0x7FFF, W0=0xFFFF, sat_flag=1.
4. **Hold.** hold=1 for 10 cycles while in FETCH -> no mem_req during the stall, final weights identical to the unstalled run, done delayed by exactly 10 cycles.
5. **Zero counts.** epochs=0 (and separately n_points=0) -> only address 0 is read, W equals the RAM word at address 0, done in cycle 3.
6. **Reset mid-run.** RST_N low during ERR -> outputs 0 immediately. A start issued while busy is ignored; a restart after reset reproduces test 1.
